// File: rtl/apb4_slave_mux.sv
`default_nettype none
// ============================================================================
// Module   : apb4_slave_mux
// Purpose  : APB4 slave multiplexer downstream of the multi-AHB-to-APB bridge.
//            Decodes the upstream PADDR into one of NUM_APB equal-size slots,
//            re-times the transfer onto a registered one-hot PSELX bus and
//            returns the selected slave's response upstream. It flags
//            unmapped accesses and, optionally, aborts hung slaves.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   NUM_APB   - number of downstream APB4 slaves
//   BASE_ADDR - address of slot 0
//   SLOT_LOG2 - log2 of slot size in bytes
//   TIMEOUT   - max ACCESS wait cycles before abort (timeout build only)
// Ports:
//   HCLK, HRESETn              - clock, asynchronous active-low reset
//   PADDR/PWDATA/PWRITE/PSEL/
//   PENABLE/PSTRB              - upstream APB4 request
//   PRDATA/PREADY/PSLVERROR    - upstream APB4 response (registered)
//   PSELX                      - one-hot downstream slave select
//   PENABLE_S/PWRITE_S/PADDR_S/
//   PWDATA_S/PSTRB_S           - shared downstream request
//   PRDATA_S/PREADY_S/PSLVERR_S- per-slave downstream response
//   decode_err                 - one-cycle pulse on unmapped access
//   timeout                    - one-cycle pulse on aborted access
// Configuration macro:
//   APB_MUX_TIMEOUT_EN - when defined, ACCESS is aborted after TIMEOUT
//                        wait cycles; otherwise ACCESS waits indefinitely
//                        and timeout is tied low.
// ============================================================================
module apb4_slave_mux #(
    parameter int unsigned NUM_APB   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned SLOT_LOG2 = 12,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    // upstream APB4 slave port
    input  logic [31:0]         PADDR,
    input  logic [31:0]         PWDATA,
    input  logic                PWRITE,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic [3:0]          PSTRB,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERROR,
    // downstream APB4 master port
    output logic [NUM_APB-1:0]  PSELX,
    output logic                PENABLE_S,
    output logic                PWRITE_S,
    output logic [31:0]         PADDR_S,
    output logic [31:0]         PWDATA_S,
    output logic [3:0]          PSTRB_S,
    input  logic [31:0]         PRDATA_S [NUM_APB],
    input  logic [NUM_APB-1:0]  PREADY_S,
    input  logic [NUM_APB-1:0]  PSLVERR_S,
    // status
    output logic                decode_err,
    output logic                timeout
);

    localparam int unsigned IDX_W = (NUM_APB > 1) ? $clog2(NUM_APB) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [NUM_APB-1:0]   pselx_q;
    logic                 penable_q;
    logic                 pwrite_q;
    logic [31:0]          paddr_q;
    logic [31:0]          pwdata_q;
    logic [3:0]           pstrb_q;
    logic [31:0]          prdata_q;
    logic                 pready_q;
    logic                 pslverr_q;
    logic                 decode_err_q;

    // ------------------------------------------------------------------
    // Address decode of the live upstream request (used only in IDLE).
    // The subtraction wraps for addresses below BASE_ADDR, so the
    // explicit below-base test is needed in addition to the slot range.
    // ------------------------------------------------------------------
    logic [31:0]          addr_off_d;
    logic [31:0]          slot_d;
    logic                 map_err_d;
    logic [IDX_W-1:0]     idx_d;
    logic [NUM_APB-1:0]   sel_onehot_d;

    assign addr_off_d = PADDR - BASE_ADDR;
    assign slot_d     = addr_off_d >> SLOT_LOG2;
    assign map_err_d  = (PADDR < BASE_ADDR) || (slot_d >= 32'(NUM_APB));
    assign idx_d      = slot_d[IDX_W-1:0];

    for (genvar gi = 0; gi < NUM_APB; gi++) begin : g_sel
        assign sel_onehot_d[gi] = (idx_d == IDX_W'(gi));
    end

    // Response of the currently addressed slave; others are ignored.
    logic                 sel_ready;
    logic                 sel_err;
    logic [31:0]          sel_rdata;

    assign sel_ready = PREADY_S[idx_q];
    assign sel_err   = PSLVERR_S[idx_q];
    assign sel_rdata = PRDATA_S[idx_q];

`ifdef APB_MUX_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0]     tmo_cnt_q;
    logic                 timeout_q;
    logic                 tmo_hit;

    // This wait cycle's increment would make the count reach TIMEOUT.
    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    // ------------------------------------------------------------------
    // Transfer FSM. Every output is a register written here; the response
    // flags default low so they form single-cycle pulses in RESP.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            pselx_q      <= '0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            prdata_q     <= '0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            decode_err_q <= 1'b0;
`ifdef APB_MUX_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            prdata_q     <= '0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            decode_err_q <= 1'b0;
`ifdef APB_MUX_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        paddr_q  <= PADDR;
                        pwdata_q <= PWDATA;
                        pwrite_q <= PWRITE;
                        // Strobes are meaningless on reads; keep them quiet.
                        pstrb_q  <= PWRITE ? PSTRB : 4'b0000;
                        if (map_err_d) begin
                            pready_q     <= 1'b1;
                            pslverr_q    <= 1'b1;
                            decode_err_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            idx_q   <= idx_d;
                            pselx_q <= sel_onehot_d;
                            state_q <= ST_SETUP;
                        end
                    end
                end

                ST_SETUP: begin
                    penable_q <= 1'b1;
`ifdef APB_MUX_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    state_q   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    // Normal completion takes priority over an abort in
                    // the same cycle.
                    if (sel_ready) begin
                        pselx_q   <= '0;
                        penable_q <= 1'b0;
                        pready_q  <= 1'b1;
                        pslverr_q <= sel_err;
                        prdata_q  <= pwrite_q ? 32'h0 : sel_rdata;
                        state_q   <= ST_RESP;
                    end
`ifdef APB_MUX_TIMEOUT_EN
                    else if (tmo_hit) begin
                        pselx_q   <= '0;
                        penable_q <= 1'b0;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= ST_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end

                ST_RESP: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign PSELX      = pselx_q;
    assign PENABLE_S  = penable_q;
    assign PWRITE_S   = pwrite_q;
    assign PADDR_S    = paddr_q;
    assign PWDATA_S   = pwdata_q;
    assign PSTRB_S    = pstrb_q;
    assign PRDATA     = prdata_q;
    assign PREADY     = pready_q;
    assign PSLVERROR  = pslverr_q;
    assign decode_err = decode_err_q;
`ifdef APB_MUX_TIMEOUT_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb4_slave_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb4_slave_mux
// Purpose  : Directed self-checking bench for apb4_slave_mux (NUM_APB=4,
//            BASE_ADDR=0x4000_0000, 4 KB slots, TIMEOUT=16). Covers the
//            timeout build when APB_MUX_TIMEOUT_EN is defined, otherwise
//            checks that a stalled slave is waited on indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb4_slave_mux;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] PADDR, PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERROR;
    logic [3:0]  PSELX;
    logic        PENABLE_S, PWRITE_S;
    logic [31:0] PADDR_S, PWDATA_S;
    logic [3:0]  PSTRB_S;
    logic [31:0] PRDATA_S [4];
    logic [3:0]  PREADY_S, PSLVERR_S;
    logic        decode_err, timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 HCLK = ~HCLK;

    apb4_slave_mux #(
        .NUM_APB  (4),
        .BASE_ADDR(32'h4000_0000),
        .SLOT_LOG2(12),
        .TIMEOUT  (16)
    ) u_dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERROR (PSLVERROR),
        .PSELX     (PSELX),
        .PENABLE_S (PENABLE_S),
        .PWRITE_S  (PWRITE_S),
        .PADDR_S   (PADDR_S),
        .PWDATA_S  (PWDATA_S),
        .PSTRB_S   (PSTRB_S),
        .PRDATA_S  (PRDATA_S),
        .PREADY_S  (PREADY_S),
        .PSLVERR_S (PSLVERR_S),
        .decode_err(decode_err),
        .timeout   (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // One upstream transfer started in the current cycle (T). The selected
    // slave holds PREADY_S low for 'waits' ACCESS cycles while every other
    // slave reports ready. exp_lat is the cycle offset of upstream PREADY.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int waits, input logic [3:0] exp_sel,
                        input logic [3:0] exp_strb, input int exp_lat,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic exp_derr, input logic exp_tmo);
        int  lat;
        bit  done;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = wdata;
        PSTRB   = strb;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 60) begin
            PREADY_S = (lat >= 2 + waits) ? 4'hF : ~exp_sel;
            tick();
            lat++;
            PENABLE = 1'b1;
            if (lat == 1) begin
                chk({tag, " sel_setup"}, 32'(PSELX), 32'(exp_sel));
                chk({tag, " pen_setup"}, 32'(PENABLE_S), 32'h0);
                chk({tag, " paddr_s"}, PADDR_S, addr);
                chk({tag, " pwdata_s"}, PWDATA_S, wdata);
                chk({tag, " pwrite_s"}, 32'(PWRITE_S), 32'(wr));
                chk({tag, " pstrb_s"}, 32'(PSTRB_S), 32'(exp_strb));
            end
            if (lat == 2 && exp_lat > 2) begin
                chk({tag, " sel_access"}, 32'(PSELX), 32'(exp_sel));
                chk({tag, " pen_access"}, 32'(PENABLE_S), 32'h1);
            end
            if (PREADY) done = 1'b1;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " prdata"}, PRDATA, exp_rdata);
        chk({tag, " pslverror"}, 32'(PSLVERROR), 32'(exp_err));
        chk({tag, " decode_err"}, 32'(decode_err), 32'(exp_derr));
        chk({tag, " timeout"}, 32'(timeout), 32'(exp_tmo));
        chk({tag, " sel_resp"}, 32'(PSELX), 32'h0);
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        PREADY_S = 4'hF;
        tick();
        chk({tag, " pready_idle"}, 32'(PREADY), 32'h0);
        chk({tag, " prdata_idle"}, PRDATA, 32'h0);
    endtask

    initial begin
        int hi_seen;
        HRESETn   = 1'b0;
        PADDR     = '0;
        PWDATA    = '0;
        PWRITE    = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        PSTRB     = '0;
        PREADY_S  = 4'hF;
        PSLVERR_S = 4'h0;
        PRDATA_S[0] = 32'h0000_A000;
        PRDATA_S[1] = 32'h1111_0001;
        PRDATA_S[2] = 32'hCAFE_0001;
        PRDATA_S[3] = 32'h3333_0003;

        #12;
        chk("rst pselx", 32'(PSELX), 32'h0);
        chk("rst penable_s", 32'(PENABLE_S), 32'h0);
        chk("rst paddr_s", PADDR_S, 32'h0);
        chk("rst pready", 32'(PREADY), 32'h0);
        chk("rst pslverror", 32'(PSLVERROR), 32'h0);
        chk("rst timeout", 32'(timeout), 32'h0);

        tick();
        HRESETn = 1'b1;
        tick();

        // tag addr wr wdata strb waits sel strb_s lat rdata err derr tmo
        xfer("rd_slot2", 32'h4000_2010, 1'b0, 32'h0, 4'hF, 0, 4'b0100, 4'b0000, 3,
             32'hCAFE_0001, 1'b0, 1'b0, 1'b0);
        xfer("wr_slot0", 32'h4000_0004, 1'b1, 32'h1234_5678, 4'b0011, 3, 4'b0001, 4'b0011, 6,
             32'h0, 1'b0, 1'b0, 1'b0);
        xfer("dec_hi", 32'h4000_4000, 1'b0, 32'h0, 4'h0, 0, 4'b0000, 4'b0000, 1,
             32'h0, 1'b1, 1'b1, 1'b0);
        xfer("dec_lo", 32'h3FFF_FFFC, 1'b0, 32'h0, 4'h0, 0, 4'b0000, 4'b0000, 1,
             32'h0, 1'b1, 1'b1, 1'b0);
        PSLVERR_S = 4'b1000;
        xfer("slverr3", 32'h4000_3FFC, 1'b0, 32'h0, 4'h0, 1, 4'b1000, 4'b0000, 4,
             32'h3333_0003, 1'b1, 1'b0, 1'b0);
        xfer("rd_slot1", 32'h4000_1FFC, 1'b0, 32'h0, 4'h0, 0, 4'b0010, 4'b0000, 3,
             32'h1111_0001, 1'b0, 1'b0, 1'b0);
        PSLVERR_S = 4'h0;

`ifdef APB_MUX_TIMEOUT_EN
        // 16 ACCESS cycles (T+2..T+17), abort response at T+18.
        xfer("tmo_slot1", 32'h4000_1000, 1'b0, 32'h0, 4'h0, 1000, 4'b0010, 4'b0000, 18,
             32'h0, 1'b1, 1'b0, 1'b1);
`else
        // Stalled slave: still waiting after 100 cycles, then completes.
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h4000_1000; PWRITE = 1'b0;
        PREADY_S = 4'b1101;
        hi_seen = 0;
        tick();
        PENABLE = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (PREADY || timeout) hi_seen++;
        end
        chk("hang no_resp", 32'(hi_seen), 32'h0);
        chk("hang pselx", 32'(PSELX), 32'b0010);
        chk("hang penable_s", 32'(PENABLE_S), 32'h1);
        PREADY_S = 4'hF;
        tick();
        chk("hang pready", 32'(PREADY), 32'h1);
        chk("hang prdata", PRDATA, 32'h1111_0001);
        PSEL = 1'b0; PENABLE = 1'b0;
        tick();
`endif

        // Reset while slave 1 is in ACCESS.
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h4000_1008; PWRITE = 1'b1;
        PWDATA = 32'hDEAD_BEEF; PSTRB = 4'hF;
        PREADY_S = 4'b1101;
        tick();
        PENABLE = 1'b1;
        tick();
        tick();
        chk("mid pselx", 32'(PSELX), 32'b0010);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst pselx", 32'(PSELX), 32'h0);
        chk("arst penable_s", 32'(PENABLE_S), 32'h0);
        chk("arst pwdata_s", PWDATA_S, 32'h0);
        chk("arst pstrb_s", 32'(PSTRB_S), 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        tick();
        HRESETn = 1'b1;
        tick();
        xfer("post_rst", 32'h4000_1004, 1'b0, 32'h0, 4'h0, 0, 4'b0010, 4'b0000, 3,
             32'h1111_0001, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb4_slave_mux.md
# apb4_slave_mux

APB4 slave multiplexer sitting directly downstream of the multi-AHB-to-APB bridge. It accepts the bridge's single APB4 master port and decodes PADDR into one of NUM_APB equal-size address slots. It re-times the transfer onto a registered per-slave PSEL bus and returns the selected slave's response upstream. It also flags decode errors and, optionally, hung slaves.

## Interface
- NUM_APB, 4, number of downstream APB4 slaves
- BASE_ADDR, 32'h4000_0000, address of slot 0
- SLOT_LOG2, 12, log2 of slot size in bytes (4 KB slots)
- TIMEOUT, 16, max ACCESS-phase wait cycles before abort (used only with timeout feature)

Ports:
- HCLK  in  1  clock; single clock domain
- HRESETn  in  1  asynchronous, active-low reset
- PADDR / PWDATA  in  32 / 32  upstream address / write data
- PWRITE, PSEL, PENABLE  in  1 each  upstream control
- PSTRB  in  4  upstream write strobes
- PRDATA  out  32  read data to upstream
- PREADY, PSLVERROR  out  1 each  upstream completion / error
- PSELX  out  NUM_APB  one-hot slave select
- PENABLE_S, PWRITE_S  out  1 each  downstream enable / direction
- PADDR_S, PWDATA_S  out  32 each  downstream address / write data
- PSTRB_S  out  4  downstream strobes
- PRDATA_S  in  32 x NUM_APB  per-slave read data (unpacked array)
- PREADY_S, PSLVERR_S  in  NUM_APB each  per-slave ready / error
- decode_err  out  1  one-cycle pulse on unmapped access
- timeout  out  1  one-cycle pulse on aborted access

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - Waits for PSEL=1 and PENABLE=0 (upstream setup phase).
  - Captures PADDR, PWDATA, PWRITE, and PSTRB into PADDR_S, PWDATA_S, PWRITE_S, and PSTRB_S. PSTRB_S is forced to 0 when PWRITE=0.
  - Computes idx = (PADDR - BASE_ADDR) >> SLOT_LOG2 with 32-bit unsigned arithmetic.
  - If PADDR < BASE_ADDR or idx >= NUM_APB, goes to RESP with error. Otherwise latches idx and goes to SETUP.
- SETUP: PSELX[idx]=1, PENABLE_S=0 for exactly one cycle, then goes to ACCESS.
- ACCESS:
  - PSELX[idx]=1, PENABLE_S=1.
  - On PREADY_S[idx]=1, captures PRDATA_S[idx] and PSLVERR_S[idx], drops PSELX and PENABLE_S, and goes to RESP.
  - PREADY_S from unselected slaves is ignored.
- RESP:
  - Drives PREADY=1 for one cycle with the captured data and error, then returns to IDLE.
  - On decode error: PRDATA=0, PSLVERROR=1, decode_err=1.
- Outside RESP: PREADY=0, PSLVERROR=0, PRDATA=0.
- On a write, PRDATA is returned as 0.
- If upstream drops PSEL mid-transfer (protocol violation), the downstream transfer still completes and RESP is still issued.

## Timing
- Reset values: all outputs 0, including PSELX, PENABLE_S, PADDR_S, PWDATA_S, PWRITE_S, PSTRB_S, PRDATA, PREADY, PSLVERROR, decode_err, and timeout.
- Reset asserted mid-transfer aborts immediately: PSELX drops asynchronously and the FSM returns to IDLE.
- All outputs are registered.
- Upstream setup sampled at cycle T gives: SETUP at T+1, ACCESS at T+2, and RESP (upstream PREADY=1) at T+3 if PREADY_S is high at T+2. Each downstream wait cycle adds one cycle.
- Decode error: RESP at T+1. No PSELX bit is asserted.
- Back-to-back transfers: the next upstream setup is accepted in the first IDLE cycle after RESP. Minimum 4 cycles per transfer.
- PSELX is one-hot or zero at all times.

## Configuration
- Macro APB_MUX_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entering ACCESS and increments each ACCESS cycle while PREADY_S[idx]=0.
  - When the count reaches TIMEOUT, the block drops PSELX and PENABLE_S and goes to RESP with PRDATA=0, PSLVERROR=1, timeout=1.
  - If PREADY_S[idx]=1 in the same cycle the count reaches TIMEOUT, normal completion wins and timeout=0.
- Undefined: ACCESS waits indefinitely; timeout is tied to 0; no counter logic is present.

## Test plan
- Read slot 2: upstream setup PADDR=0x4000_2010, slave 2 returns PRDATA_S=0xCAFE_0001 with PREADY_S=1 immediately -> PSELX=4'b0100 at T+1 and T+2, PENABLE_S=1 at T+2, PRDATA=0xCAFE_0001 and PREADY=1 at T+3.
- Write slot 0 with 3 wait states: PADDR=0x4000_0004, PWDATA=0x1234_5678, PSTRB=4'b0011 -> PWDATA_S=0x1234_5678, PSTRB_S=4'b0011, upstream PREADY=1 at T+6, PRDATA=0.
- Decode error: PADDR=0x4000_4000 and separately 0x3FFF_FFFC -> PSELX stays 0, PREADY=1, PSLVERROR=1, decode_err=1 at T+1.
- Slave error: slave 3 returns PSLVERR_S=1 -> PSLVERROR=1 at RESP; next transfer to slot 1 completes cleanly.
- Timeout (macro on, TIMEOUT=16): slave 1 never ready -> PSELX drops after 16 ACCESS cycles, then PREADY=1, PSLVERROR=1, timeout=1. With the macro off, the block still waits after 100 cycles.
- Reset mid-ACCESS: HRESETn low with PSELX=4'b0010 -> all outputs 0 immediately; a new transfer after release completes normally.
